angle_color_unit: RTL and testbench

Registered helper that bundles the three small arithmetic functions the tangram control core needs every frame:
- circular ±1-degree stepping of a shape angle;
- fixed-point cosine lookup by whole degree;
- the 128×128 colour-picker map, which gives the colour under the cursor and the rendered picker pixel.

It sits between the control FSM and the renderer. All outputs are registered with one cycle of latency.

---
 rtl/tangram_math_pkg.sv | 18 +
 rtl/cos_quarter_rom.sv | 109 ++++++++++
 rtl/angle_color_unit.sv | 133 +++++++++++++
 tb/tb_angle_color_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tangram_math_pkg.sv
// Shared fixed-point constants and types for the tangram arithmetic blocks.
// Angles are whole degrees; fractional values are Q(INT_BITS).(FLOAT_DCM_BITS).
package tangram_math_pkg;

    localparam int INT_BITS       = 16;
    localparam int FLOAT_DCM_BITS = 16;
    localparam int FLOAT_BITS     = INT_BITS + FLOAT_DCM_BITS;
    localparam int ONE            = 1 << FLOAT_DCM_BITS;

    // A quarter-wave cosine sample needs one extra bit so that cos(0) = ONE fits.
    localparam int COS_Q_BITS     = FLOAT_DCM_BITS + 1;
    localparam int DEG_QUARTER    = 90;
    localparam int DEG_HALF       = 180;

    typedef logic [COS_Q_BITS-1:0] cos_q_t;
    typedef logic [6:0]            cos_idx_t;

endpackage

// File: rtl/cos_quarter_rom.sv
// Combinational quarter-wave cosine table: q = round(65536 * cos(deg)) for deg 0..90.
// Indices above 90 return 0; the caller folds every angle into that range first.
module cos_quarter_rom
    import tangram_math_pkg::*;
(
    input  cos_idx_t deg,
    output cos_q_t   q
);

    always_comb begin
        // NOTE: default assignment first so every path drives q and no latch is inferred.
        q = '0;
        case (deg)
            7'd0:  q = cos_q_t'(ONE);
            7'd1:  q = 17'd65526;
            7'd2:  q = 17'd65496;
            7'd3:  q = 17'd65446;
            7'd4:  q = 17'd65376;
            7'd5:  q = 17'd65287;
            7'd6:  q = 17'd65177;
            7'd7:  q = 17'd65048;
            7'd8:  q = 17'd64898;
            7'd9:  q = 17'd64729;
            7'd10: q = 17'd64540;
            7'd11: q = 17'd64332;
            7'd12: q = 17'd64104;
            7'd13: q = 17'd63856;
            7'd14: q = 17'd63589;
            7'd15: q = 17'd63303;
            7'd16: q = 17'd62997;
            7'd17: q = 17'd62672;
            7'd18: q = 17'd62328;
            7'd19: q = 17'd61966;
            7'd20: q = 17'd61584;
            7'd21: q = 17'd61183;
            7'd22: q = 17'd60764;
            7'd23: q = 17'd60326;
            7'd24: q = 17'd59870;
            7'd25: q = 17'd59396;
            7'd26: q = 17'd58903;
            7'd27: q = 17'd58393;
            7'd28: q = 17'd57865;
            7'd29: q = 17'd57319;
            7'd30: q = 17'd56756;
            7'd31: q = 17'd56175;
            7'd32: q = 17'd55578;
            7'd33: q = 17'd54963;
            7'd34: q = 17'd54332;
            7'd35: q = 17'd53684;
            7'd36: q = 17'd53020;
            7'd37: q = 17'd52339;
            7'd38: q = 17'd51643;
            7'd39: q = 17'd50931;
            7'd40: q = 17'd50203;
            7'd41: q = 17'd49461;
            7'd42: q = 17'd48703;
            7'd43: q = 17'd47930;
            7'd44: q = 17'd47143;
            7'd45: q = 17'd46341;
            7'd46: q = 17'd45525;
            7'd47: q = 17'd44695;
            7'd48: q = 17'd43852;
            7'd49: q = 17'd42995;
            7'd50: q = 17'd42126;
            7'd51: q = 17'd41243;
            7'd52: q = 17'd40348;
            7'd53: q = 17'd39441;
            7'd54: q = 17'd38521;
            7'd55: q = 17'd37590;
            7'd56: q = 17'd36647;
            7'd57: q = 17'd35693;
            7'd58: q = 17'd34729;
            7'd59: q = 17'd33754;
            7'd60: q = 17'd32768;
            7'd61: q = 17'd31772;
            7'd62: q = 17'd30767;
            7'd63: q = 17'd29753;
            7'd64: q = 17'd28729;
            7'd65: q = 17'd27697;
            7'd66: q = 17'd26656;
            7'd67: q = 17'd25607;
            7'd68: q = 17'd24550;
            7'd69: q = 17'd23486;
            7'd70: q = 17'd22415;
            7'd71: q = 17'd21336;
            7'd72: q = 17'd20252;
            7'd73: q = 17'd19161;
            7'd74: q = 17'd18064;
            7'd75: q = 17'd16962;
            7'd76: q = 17'd15855;
            7'd77: q = 17'd14742;
            7'd78: q = 17'd13626;
            7'd79: q = 17'd12505;
            7'd80: q = 17'd11380;
            7'd81: q = 17'd10252;
            7'd82: q = 17'd9121;
            7'd83: q = 17'd7987;
            7'd84: q = 17'd6850;
            7'd85: q = 17'd5712;
            7'd86: q = 17'd4572;
            7'd87: q = 17'd3430;
            7'd88: q = 17'd2287;
            7'd89: q = 17'd1144;
            7'd90: q = 17'd0;
            default: q = '0;
        endcase
    end

endmodule

// File: rtl/angle_color_unit.sv
// Per-frame arithmetic helper for the tangram control core: angle stepping,
// cosine lookup and the colour-picker map. All outputs are registered (1 cycle).
module angle_color_unit #(
    parameter int INT_BITS       = tangram_math_pkg::INT_BITS,
    parameter int FLOAT_DCM_BITS = tangram_math_pkg::FLOAT_DCM_BITS,
    parameter int FLOAT_BITS     = tangram_math_pkg::FLOAT_BITS,
    parameter int PIXLW          = 12,
    parameter int CSIZE          = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [INT_BITS-1:0]   angle_in,
    input  logic signed [INT_BITS-1:0]   cos_in,
    input  logic        [INT_BITS-1:0]   x,
    input  logic        [INT_BITS-1:0]   y,
    input  logic        [INT_BITS-1:0]   sx,
    input  logic        [INT_BITS-1:0]   sy,
    output logic signed [INT_BITS-1:0]   prev,
    output logic signed [INT_BITS-1:0]   next,
    output logic signed [FLOAT_BITS-1:0] cos_out,
    output logic        [PIXLW-1:0]      color,
    output logic        [PIXLW-1:0]      render
);

    import tangram_math_pkg::*;

    localparam int CW = $clog2(CSIZE);
    localparam int DW = INT_BITS + 1;

    localparam logic signed [INT_BITS-1:0] ANG_MIN  = INT_BITS'(-DEG_HALF);
    localparam logic signed [INT_BITS-1:0] ANG_MAX  = INT_BITS'(DEG_HALF - 1);
    localparam logic signed [INT_BITS-1:0] ANG_STEP = INT_BITS'(1);
    localparam logic signed [DW-1:0]       MARK_ARM = DW'(3);
    localparam logic signed [DW-1:0]       ZERO_DW  = '0;
    localparam logic        [INT_BITS-1:0] CSIZE_W  = INT_BITS'(CSIZE);

    typedef logic [PIXLW-1:0] pix_t;

    // Picker map: R and G are the top nibble of each coordinate, B fills in so
    // the square fades from blue (origin) toward yellow (far corner).
    function automatic pix_t color_of(input logic [CW-1:0] u, input logic [CW-1:0] v);
        logic [4:0] r5;
        logic [4:0] g5;
        logic [4:0] b5;
        r5 = {1'b0, u[CW-1 -: 4]};
        g5 = {1'b0, v[CW-1 -: 4]};
        b5 = 5'd15 - ((r5 + g5) >> 1);
        return pix_t'({u[CW-1 -: 4], v[CW-1 -: 4], b5[3:0]});
    endfunction

    // Angle stepping with wrap on the half-open range [-180, 180).
    logic signed [INT_BITS-1:0] prev_d;
    logic signed [INT_BITS-1:0] next_d;

    always_comb begin
        prev_d = (angle_in <= ANG_MIN) ? ANG_MAX : angle_in - ANG_STEP;
        next_d = (angle_in >= ANG_MAX) ? ANG_MIN : angle_in + ANG_STEP;
    end

    // Cosine: fold |angle| (clamped to 180) onto the 0..90 quarter table.
    logic signed [DW-1:0]         cos_wide;
    logic signed [DW-1:0]         cos_abs;
    logic        [7:0]            cos_deg;
    cos_idx_t                     rom_idx;
    logic                         cos_neg;
    cos_q_t                       rom_q;
    logic signed [FLOAT_BITS-1:0] cos_mag;
    logic signed [FLOAT_BITS-1:0] cos_d;

    always_comb begin
        cos_wide = DW'(cos_in);
        cos_abs  = cos_wide[DW-1] ? -cos_wide : cos_wide;
        cos_deg  = (cos_abs > DW'(DEG_HALF)) ? 8'(DEG_HALF) : cos_abs[7:0];
        if (cos_deg <= 8'(DEG_QUARTER)) begin
            rom_idx = cos_deg[6:0];
            cos_neg = 1'b0;
        end else begin
            rom_idx = 7'(8'(DEG_HALF) - cos_deg);
            cos_neg = 1'b1;
        end
        cos_mag = FLOAT_BITS'(rom_q);
        cos_d   = cos_neg ? -cos_mag : cos_mag;
    end

    cos_quarter_rom u_cos_rom (
        .deg (rom_idx),
        .q   (rom_q)
    );

    // Picker colour at the cursor and the rendered pixel with crosshair marker.
    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic                 in_range;
    logic                 on_cross;
    pix_t                 pix_f;
    pix_t                 color_d;
    pix_t                 render_d;

    always_comb begin
        dx       = $signed({1'b0, sx}) - $signed({1'b0, x});
        dy       = $signed({1'b0, sy}) - $signed({1'b0, y});
        in_range = (sx < CSIZE_W) && (sy < CSIZE_W);
        on_cross = ((dx == ZERO_DW) && (dy >= -MARK_ARM) && (dy <= MARK_ARM)) ||
                   ((dy == ZERO_DW) && (dx >= -MARK_ARM) && (dx <= MARK_ARM));
        pix_f    = color_of(sx[CW-1:0], sy[CW-1:0]);
        color_d  = color_of(x[CW-1:0], y[CW-1:0]);
        if (!in_range) begin
            render_d = '0;
        end else if (on_cross) begin
            render_d = ~pix_f;
        end else begin
            render_d = pix_f;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            prev    <= '0;
            next    <= '0;
            cos_out <= '0;
            color   <= '0;
            render  <= '0;
        end else begin
            prev    <= prev_d;
            next    <= next_d;
            cos_out <= cos_d;
            color   <= color_d;
            render  <= render_d;
        end
    end

endmodule

// File: tb/tb_angle_color_unit.sv
// Directed self-checking bench for angle_color_unit: stepping wrap, cosine
// points, picker colour, crosshair render, reset and one-cycle latency.
module tb_angle_color_unit;

    logic               clk;
    logic               rst;
    logic signed [15:0] angle_in;
    logic signed [15:0] cos_in;
    logic        [15:0] x;
    logic        [15:0] y;
    logic        [15:0] sx;
    logic        [15:0] sy;
    logic signed [15:0] prev;
    logic signed [15:0] next;
    logic signed [31:0] cos_out;
    logic        [11:0] color;
    logic        [11:0] render;

    int total = 0;
    int bad   = 0;

    angle_color_unit dut (
        .clk      (clk),
        .rst      (rst),
        .angle_in (angle_in),
        .cos_in   (cos_in),
        .x        (x),
        .y        (y),
        .sx       (sx),
        .sy       (sy),
        .prev     (prev),
        .next     (next),
        .cos_out  (cos_out),
        .color    (color),
        .render   (render)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        angle_in = 16'sd5;
        cos_in   = 16'sd30;
        x = 16'd10; y = 16'd20; sx = 16'd10; sy = 16'd20;
        tick();
        rst = 1'b1;
        tick();
        total += 5;
        if (prev    !== 16'sd0) begin bad++; $display("FAIL reset_prev got=%0d want=0", prev); end
        if (next    !== 16'sd0) begin bad++; $display("FAIL reset_next got=%0d want=0", next); end
        if (cos_out !== 32'sd0) begin bad++; $display("FAIL reset_cos got=%0d want=0", cos_out); end
        if (color   !== 12'h000) begin bad++; $display("FAIL reset_color got=%h want=000", color); end
        if (render  !== 12'h000) begin bad++; $display("FAIL reset_render got=%h want=000", render); end
        rst = 1'b0;
        tick();
        // f(10,20) = R1 G2 B(15-1)=E ; (sx,sy)==(x,y) sits on the crosshair -> inverted
        total += 5;
        if (prev    !== 16'sd4)     begin bad++; $display("FAIL post_reset_prev got=%0d want=4", prev); end
        if (next    !== 16'sd6)     begin bad++; $display("FAIL post_reset_next got=%0d want=6", next); end
        if (cos_out !== 32'sd56756) begin bad++; $display("FAIL post_reset_cos got=%0d want=56756", cos_out); end
        if (color   !== 12'h12E)    begin bad++; $display("FAIL post_reset_color got=%h want=12e", color); end
        if (render  !== 12'hED1)    begin bad++; $display("FAIL post_reset_render got=%h want=ed1", render); end
    endtask

    task automatic test_stepping;
        int ain [5] = '{-180, 179, 0, -200, 200};
        int pexp[5] = '{ 179, 178, -1, 179, 199};
        int nexp[5] = '{-179, -180, 1, -199, -180};
        for (int i = 0; i < 5; i++) begin
            angle_in = 16'(ain[i]);
            tick();
            total += 2;
            if (prev !== 16'(pexp[i])) begin
                bad++; $display("FAIL step_prev[%0d] in=%0d got=%0d want=%0d", i, ain[i], prev, pexp[i]);
            end
            if (next !== 16'(nexp[i])) begin
                bad++; $display("FAIL step_next[%0d] in=%0d got=%0d want=%0d", i, ain[i], next, nexp[i]);
            end
        end
    endtask

    task automatic test_cosine;
        int cin [10] = '{0, 60, 90, 120, 180, -60, 250, -32768, 45, -135};
        int cexp[10] = '{65536, 32768, 0, -32768, -65536, 32768, -65536, -65536, 46341, -46341};
        for (int i = 0; i < 10; i++) begin
            cos_in = 16'(cin[i]);
            tick();
            total++;
            if (cos_out !== cexp[i]) begin
                bad++; $display("FAIL cos[%0d] in=%0d got=%0d want=%0d", i, cin[i], cos_out, cexp[i]);
            end
        end
    endtask

    task automatic test_color;
        int          xin[3] = '{127, 0, 40};
        int          yin[3] = '{0, 0, 100};
        logic [11:0] cexp[3] = '{12'hF08, 12'h00F, 12'h5C7};
        for (int i = 0; i < 3; i++) begin
            x = 16'(xin[i]);
            y = 16'(yin[i]);
            tick();
            total++;
            if (color !== cexp[i]) begin
                bad++; $display("FAIL color[%0d] x=%0d y=%0d got=%h want=%h", i, xin[i], yin[i], color, cexp[i]);
            end
        end
    endtask

    task automatic test_render;
        // cursor at (64,64); f(64,67)=887, f(61,64)=788
        int          sxin[6] = '{64, 64, 128, 61, 60, 64};
        int          syin[6] = '{67, 68, 10, 64, 64, 130};
        logic [11:0] rexp[6] = '{12'h778, 12'h887, 12'h000, 12'h877, 12'h788, 12'h000};
        x = 16'd64;
        y = 16'd64;
        for (int i = 0; i < 6; i++) begin
            sx = 16'(sxin[i]);
            sy = 16'(syin[i]);
            tick();
            total++;
            if (render !== rexp[i]) begin
                bad++; $display("FAIL render[%0d] sx=%0d sy=%0d got=%h want=%h", i, sxin[i], syin[i], render, rexp[i]);
            end
        end
    endtask

    task automatic test_latency;
        int seq [6] = '{10, -180, 179, -5, 100, -179};
        int pexp[6] = '{9, 179, 178, -6, 99, -180};
        int nexp[6] = '{11, -179, -180, -4, 101, -178};
        angle_in = 16'(seq[0]);
        tick();
        for (int i = 1; i < 6; i++) begin
            angle_in = 16'(seq[i]);
            #2;
            total++;
            if (prev !== 16'(pexp[i-1]) || next !== 16'(nexp[i-1])) begin
                bad++; $display("FAIL latency_hold[%0d] got=%0d/%0d want=%0d/%0d", i, prev, next, pexp[i-1], nexp[i-1]);
            end
            tick();
            total++;
            if (prev !== 16'(pexp[i]) || next !== 16'(nexp[i])) begin
                bad++; $display("FAIL latency_update[%0d] got=%0d/%0d want=%0d/%0d", i, prev, next, pexp[i], nexp[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        angle_in = '0; cos_in = '0;
        x = '0; y = '0; sx = '0; sy = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_stepping();
        test_cosine();
        test_color();
        test_render();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
